fetch_issue_unit: RTL
=====================

Name: fetch_issue_unit

Overview:
- Instruction fetch stage that produces the decoded instruction fields (opcode, immediate flag, register indices, immediate value) consumed by the decode/control stage.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers a fetched word in a one-entry skid buffer under stall, and flushes on redirect from execute.
- Halts fetch after issuing a STOP opcode.

Parameters:
PC_W, 10, width of the word-addressed PC and memory address.
RESET_PC, 0, PC loaded on reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
stall  in  1  decode stage cannot accept; hold ID outputs
redirect  in  1  taken branch/jump from execute; flush and refetch
redirect_pc  in  PC_W  absolute word address of the redirect target
imem_en  out  1  memory read enable
imem_addr  out  PC_W  memory read address
imem_rdata  in  32  instruction word, valid the cycle after imem_en
id_valid  out  1  ID fields hold a real instruction
id_op  out  4  instr[31:28]
id_imm  out  1  instr[27]
id_rd  out  4  instr[26:23]
id_rs1  out  4  instr[22:19]
id_rs2  out  4  instr[18:15], meaningful only when id_imm=0
id_immval  out  32  instr[18:0] sign-extended from bit 18
id_pc  out  PC_W  address of the instruction in ID
halted  out  1  fetch stopped after STOP

Behaviour:
- Reset (async, any cycle):
  - pc_q=RESET_PC; state=RUN.
  - inflight_valid, skid_valid, id_valid and halted are 0.
  - All ID fields are 0.
  - An in-flight read is discarded.
- imem_en and imem_addr are combinational:
  - imem_en = redirect | (state==RUN & !stall).
  - imem_addr = redirect ? redirect_pc : pc_q.
- Issue bookkeeping: when imem_en=1, set pc_q<=imem_addr+1 (wraps mod 2^PC_W), inflight_valid<=1 and inflight_pc<=imem_addr. Otherwise set inflight_valid<=0.
- Arrival: when inflight_valid=1, imem_rdata belongs to inflight_pc.
  - If !stall and skid empty: write it to the ID registers (id_valid<=1).
  - If stall: write it to the skid register (skid_valid<=1). The skid register cannot overflow because imem_en=0 while stall=1.
- Unstall: on the first !stall cycle with skid_valid=1, load ID from the skid and clear skid_valid. The fetch issued in that same cycle arrives next cycle, so order is preserved.
- Stall with nothing arriving: ID registers hold. If !stall and nothing arrives, id_valid<=0.
- Redirect has priority over stall and over HALT:
  - id_valid, skid_valid and the inflight arrival are all discarded.
  - state<=RUN and halted<=0.
  - Fetch is issued from redirect_pc.
  - The target is in ID (id_valid=1) two edges after redirect is sampled.
- STOP (opcode 4'b1101):
  - When a STOP word is loaded into ID or into the skid, set state<=HALT and halted<=1.
  - The word issued in the same cycle (STOP pc+1) is discarded on arrival.
  - pc_q is left at STOP pc+1.
  - The STOP itself is presented once with id_valid=1 and held while stall=1. After it is accepted, id_valid=0.
  - In HALT, imem_en=0 until redirect or reset.
- Opcodes 1100, 1110 and 1111 pass through unmodified; decode treats them as NOP.
- Throughput is one instruction per cycle with no stall or redirect. The first id_valid=1 occurs at the second rising edge after rst deasserts.

Decomposition:
- Shared package cpu_pkg holds:
  - the opcode enum: ADD 0000, SUB 0001, AND 0010, ORR 0011, LSL 0100, CMP 0101, SET 0110, LDR 0111, STR 1000, B 1001, BEQ 1010, BGE 1011, STOP 1101;
  - field position constants;
  - the IMM_W=19 constant;
  - a packed struct id_fields_t.
- Sub-module fetch_skid_buf: a one-entry buffer with load/unload/flush holding {word, pc}.

Test Plan:
- Reset release with memory[0..3] = ADD, SUB, AND, ORR and no stall -> id_op sequence 0000, 0001, 0010, 0011 on consecutive cycles starting at the 2nd edge; id_pc = 0, 1, 2, 3.
- stall=1 for 3 cycles while word 2 (imm=1, instr[18:0]=19'h7FFFF) arrives -> ID holds word 1 and the skid captures word 2. After release, ID shows word 2 with id_immval=32'hFFFFFFFF, then word 3; no word is lost or duplicated.
- redirect=1 with redirect_pc=0x040 while stall=1 and the skid is full -> skid and ID are flushed. Two edges later id_valid=1, id_pc=0x040.
- STOP at address 5 -> halted=1 and STOP is presented once. Word 6 never appears, imem_en stays 0 for 10 cycles, and pc_q=6.
- In HALT, redirect to 0x010 -> halted=0 and fetch resumes, with id_pc=0x010 after two edges.
- Async rst asserted mid-stall with the skid full -> all outputs go to 0 immediately without a clock edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding, instruction field positions and the
// decoded-field record handed from fetch to decode.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_ORR  = 4'b0011,
        OP_LSL  = 4'b0100,
        OP_CMP  = 4'b0101,
        OP_SET  = 4'b0110,
        OP_LDR  = 4'b0111,
        OP_STR  = 4'b1000,
        OP_B    = 4'b1001,
        OP_BEQ  = 4'b1010,
        OP_BGE  = 4'b1011,
        OP_STOP = 4'b1101
    } opcode_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    localparam int OP_LSB  = 28;
    localparam int IMM_BIT = 27;
    localparam int RD_LSB  = 23;
    localparam int RS1_LSB = 19;
    localparam int RS2_LSB = 15;
    localparam int IMM_W   = 19;

    typedef struct packed {
        logic [3:0]  op;
        logic        imm;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] immval;
    } id_fields_t;

    // Unused opcodes (1100, 1110, 1111) pass through untouched.
    function automatic id_fields_t decode_word(input logic [31:0] word);
        id_fields_t f;
        f.op     = word[OP_LSB +: 4];
        f.imm    = word[IMM_BIT];
        f.rd     = word[RD_LSB +: 4];
        f.rs1    = word[RS1_LSB +: 4];
        f.rs2    = word[RS2_LSB +: 4];
        f.immval = {{(32 - IMM_W){word[IMM_W-1]}}, word[IMM_W-1:0]};
        return f;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched {word, pc} while decode is stalled.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            unload,
    input  logic            flush,
    input  logic [31:0]     load_word,
    input  logic [PC_W-1:0] load_pc,
    output logic            valid,
    output logic [31:0]     word,
    output logic [PC_W-1:0] pc
);

    logic            valid_q, valid_d;
    logic [31:0]     word_q, word_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        // NOTE: defaults first, so no path leaves a signal unassigned and no latch is inferred.
        valid_d = valid_q;
        word_d  = word_q;
        pc_d    = pc_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            word_d  = load_word;
            pc_d    = load_pc;
        end else if (unload) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // NOTE: the payload is not reset; valid_q alone says whether it means anything.
    always_ff @(posedge clk) begin
        word_q <= word_d;
        pc_q   <= pc_d;
    end

    assign valid = valid_q;
    assign word  = word_q;
    assign pc    = pc_q;

endmodule

// File: rtl/fetch_issue_unit.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous instruction memory,
// and presents decoded fields to ID with stall skid, redirect flush and STOP halt.
module fetch_issue_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_en,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [3:0]      id_op,
    output logic            id_imm,
    output logic [3:0]      id_rd,
    output logic [3:0]      id_rs1,
    output logic [3:0]      id_rs2,
    output logic [31:0]     id_immval,
    output logic [PC_W-1:0] id_pc,
    output logic            halted
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            inflight_valid_q, inflight_valid_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            id_valid_q, id_valid_d;
    id_fields_t      id_q, id_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;

    logic            arrive, stop_arrive, skid_load, skid_unload;
    logic            skid_valid;
    logic [31:0]     skid_word;
    logic [PC_W-1:0] skid_pc;

    always_comb begin
        imem_en     = redirect | (state_q == ST_RUN && !stall);
        imem_addr   = redirect ? redirect_pc : pc_q;
        // Anything in flight while halted is the word after STOP and is dropped.
        arrive      = inflight_valid_q && !redirect && state_q == ST_RUN;
        stop_arrive = arrive && (imem_rdata[OP_LSB +: 4] == OP_STOP);
        skid_load   = arrive && stall;
        skid_unload = !redirect && !stall && skid_valid;
    end

    fetch_skid_buf #(.PC_W(PC_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .unload    (skid_unload),
        .flush     (redirect),
        .load_word (imem_rdata),
        .load_pc   (inflight_pc_q),
        .valid     (skid_valid),
        .word      (skid_word),
        .pc        (skid_pc)
    );

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        inflight_valid_d = imem_en;
        inflight_pc_d    = inflight_pc_q;
        id_valid_d       = id_valid_q;
        id_d             = id_q;
        id_pc_d          = id_pc_q;

        // PC does not advance past STOP+1 even though that word is still issued.
        if (imem_en) begin
            inflight_pc_d = imem_addr;
            if (!stop_arrive) pc_d = imem_addr + PC_W'(1);
        end

        if (redirect)         state_d = ST_RUN;
        else if (stop_arrive) state_d = ST_HALT;

        if (redirect) begin
            id_valid_d = 1'b0;
        end else if (skid_unload) begin
            id_valid_d = 1'b1;
            id_d       = decode_word(skid_word);
            id_pc_d    = skid_pc;
        end else if (!stall) begin
            id_valid_d = arrive;
            if (arrive) begin
                id_d    = decode_word(imem_rdata);
                id_pc_d = inflight_pc_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            pc_q             <= RESET_PC;
            inflight_valid_q <= 1'b0;
            inflight_pc_q    <= '0;
            id_valid_q       <= 1'b0;
            id_q             <= '0;
            id_pc_q          <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            inflight_valid_q <= inflight_valid_d;
            inflight_pc_q    <= inflight_pc_d;
            id_valid_q       <= id_valid_d;
            id_q             <= id_d;
            id_pc_q          <= id_pc_d;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_op     = id_q.op;
    assign id_imm    = id_q.imm;
    assign id_rd     = id_q.rd;
    assign id_rs1    = id_q.rs1;
    assign id_rs2    = id_q.rs2;
    assign id_immval = id_q.immval;
    assign id_pc     = id_pc_q;
    assign halted    = (state_q == ST_HALT);

endmodule
